// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-level UART transmitter. Each accepted byte is sent on tx_serial as a
// start bit (0), eight data bits LSB first, an optional parity bit, and one
// stop bit (1). Every bit is held for CLKS_PER_BIT clock cycles.
//
// A one-deep pending buffer holds a byte requested while a frame is in
// flight. The next frame then starts on the cycle after tx_done, with no
// idle gap. A request that finds the buffer already full is dropped, and
// the sticky overrun flag is set.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   PARITY_EN     1 = insert a parity bit between the data and the stop bit
//   PARITY_ODD    parity sense when enabled: 0 = even, 1 = odd
//
// Ports
//   clock      in   system clock; all state changes on the rising edge
//   reset      in   asynchronous, active-low reset
//   tx_byte    in   [7:0] byte to send; read only in the cycle send = 1
//   send       in   one-cycle request to transmit tx_byte
//   tx_serial  out  serial line; high when idle
//   tx_active  out  high from the first start-bit cycle to the last stop-bit cycle
//   tx_done    out  one-cycle pulse on the last cycle of each stop bit
//   overrun    out  sticky; set when a request is dropped, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       send,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       tx_done,
  output logic       overrun
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Registered state
  state_t            r_state;
  logic [7:0]        r_shift;      // byte of the frame now on the line
  logic [BAUD_W-1:0] r_baud;       // cycle index within the current bit
  logic [2:0]        r_bit_idx;    // data bit index, 0..7
  logic              r_pend_full;
  logic [7:0]        r_pend_byte;
  logic              r_overrun;

  // Next-state values
  state_t            w_state_nxt;
  logic [7:0]        w_shift_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_bit_idx_nxt;
  logic              w_pend_full_nxt;
  logic [7:0]        w_pend_byte_nxt;
  logic              w_overrun_nxt;

  // Decodes of the current state
  logic w_bit_end;     // last cycle of the current bit
  logic w_last_stop;   // last cycle of the stop bit, which is the tx_done cycle
  logic w_busy;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end;
  assign w_busy      = (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written below takes a default first. Any path that
    // does not assign a signal then holds the default, so no latch is inferred.
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_baud_nxt      = r_baud;
    w_bit_idx_nxt   = r_bit_idx;
    w_pend_full_nxt = r_pend_full;
    w_pend_byte_nxt = r_pend_byte;
    w_overrun_nxt   = r_overrun;
    tx_serial       = 1'b1;
    tx_active       = w_busy;
    tx_done         = w_last_stop;
    overrun         = r_overrun;

    // The baud counter runs only inside a frame. It wraps to 0 at the end
    // of every bit, so it is already 0 when the FSM re-enters IDLE or START.
    if (w_busy) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        tx_serial = 1'b1;
        if (r_pend_full) begin
          w_shift_nxt     = r_pend_byte;
          w_pend_full_nxt = 1'b0;
          w_state_nxt     = S_START;
          // This case cannot occur, because the buffer is always drained at
          // the end of STOP. It is handled so that a request here still
          // refills the buffer.
          if (send) begin
            w_pend_byte_nxt = tx_byte;
            w_pend_full_nxt = 1'b1;
          end
        end else if (send) begin
          w_shift_nxt = tx_byte;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        tx_serial = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        tx_serial = r_shift[r_bit_idx];
        if (w_bit_end) begin
          // The 3-bit index wraps 7 -> 0, so it is ready for the next frame.
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        tx_serial = (^r_shift) ^ PARITY_ODD;
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        tx_serial = 1'b1;
        if (w_bit_end) begin
          // A buffered byte goes first. A request in this same cycle is
          // then a second byte that has nowhere to go.
          if (r_pend_full) begin
            w_shift_nxt     = r_pend_byte;
            w_pend_full_nxt = 1'b0;
            w_state_nxt     = S_START;
            if (send) begin
              w_overrun_nxt = 1'b1;
            end
          end else if (send) begin
            w_shift_nxt = tx_byte;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A request during a frame, outside the tx_done cycle, goes to the
    // pending buffer. It is dropped if the buffer is already full.
    if (send && w_busy && !w_last_stop) begin
      if (r_pend_full) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_pend_byte_nxt = tx_byte;
        w_pend_full_nxt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the data registers (shift, pending byte) are also reset. They are
  // few bits, and resetting them keeps the line output deterministic straight
  // after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_pend_full <= 1'b0;
      r_pend_byte <= '0;
      r_overrun   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments. Every register updates from the
      // values before the edge, whatever order the statements are in.
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_baud      <= w_baud_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_pend_byte <= w_pend_byte_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer at CLKS_PER_BIT = 4. It drives three
// instances from the same inputs: no parity, even parity and odd parity. The
// parity instances are checked only on the first frame. Line bits are
// captured once per cycle and compared with expected frames built from the
// bytes sent.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic [7:0] tx_byte;
  logic       send;

  logic tx_serial_0, tx_active_0, tx_done_0, overrun_0;
  logic tx_serial_e, tx_active_e, tx_done_e, overrun_e;
  logic tx_serial_o, tx_active_o, tx_done_o, overrun_o;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
    .clock(clock), .reset(reset), .tx_byte(tx_byte), .send(send),
    .tx_serial(tx_serial_0), .tx_active(tx_active_0), .tx_done(tx_done_0), .overrun(overrun_0)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_even (
    .clock(clock), .reset(reset), .tx_byte(tx_byte), .send(send),
    .tx_serial(tx_serial_e), .tx_active(tx_active_e), .tx_done(tx_done_e), .overrun(overrun_e)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_odd (
    .clock(clock), .reset(reset), .tx_byte(tx_byte), .send(send),
    .tx_serial(tx_serial_o), .tx_active(tx_active_o), .tx_done(tx_done_o), .overrun(overrun_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;   // tx_done pulses of u_dut, counted on the falling edge

  always @(negedge clock) begin
    if (tx_done_0) done_cnt++;
  end

  // Captured per-cycle results, filled in by run_seq
  logic [127:0] obs;
  int act_cnt, done_first, done_last, n_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds send high for one cycle. tx_byte changes right after the sampling
  // edge, because the DUT must not depend on it staying stable.
  task automatic send_byte(input logic [7:0] b);
    send = 1'b1;
    tx_byte = b;
    tick();
    send = 1'b0;
    tx_byte = ~b;
  endtask

  // Expected line level per cycle. Bit i is cycle i+1 of the frame; cycles
  // after the stop bit read as idle (1).
  function automatic logic [127:0] frame_line(input logic [7:0] b, input bit pen, input bit podd);
    logic [10:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    n = 9;
    if (pen) begin
      bits[9] = (^b) ^ podd;
      n = 10;
    end
    bits[n] = 1'b1;
    frame_line = '1;
    for (int k = 0; k < 11; k++)
      for (int j = 0; j < CPB; j++)
        frame_line[k*CPB+j] = bits[k];
  endfunction

  // Sends b1, then optionally b2 in cycle at2 and b3 in cycle at3, counted
  // from the first frame cycle (at = 0 means no request). Samples u_dut for
  // ncyc cycles.
  task automatic run_seq(input logic [7:0] b1, input int at2, input logic [7:0] b2,
                         input int at3, input logic [7:0] b3, input int ncyc);
    obs = '1;
    act_cnt = 0;
    done_first = 0;
    done_last = 0;
    n_done = 0;
    send_byte(b1);
    for (int c = 1; c <= ncyc; c++) begin
      obs[c-1] = tx_serial_0;
      if (tx_active_0) act_cnt++;
      if (tx_done_0) begin
        n_done++;
        if (done_first == 0) done_first = c;
        done_last = c;
      end
      if (c == at2) begin
        send = 1'b1;
        tx_byte = b2;
      end else if (c == at3) begin
        send = 1'b1;
        tx_byte = b3;
      end else begin
        send = 1'b0;
        tx_byte = 8'h00;
      end
      tick();
    end
    send = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] fl, fl2;
    logic [43:0]  ob_e, ob_o;
    int act_e, act_o, da_0, da_e, da_o, d0, dat;
    logic [7:0] msg [0:6];

    // ---------------- reset state ----------------
    reset = 1'b0;
    send = 1'b0;
    tx_byte = 8'h00;
    #2;
    check("rst_serial", 64'(tx_serial_0), 64'd1);
    check("rst_active", 64'(tx_active_0), 64'd0);
    check("rst_done",   64'(tx_done_0),   64'd0);
    check("rst_overrun", 64'(overrun_0),  64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // ---------------- 0x41, all three parity settings ----------------
    d0 = done_cnt;
    send_byte(8'h41);
    obs = '1; ob_e = '1; ob_o = '1;
    act_cnt = 0; act_e = 0; act_o = 0; da_0 = 0; da_e = 0; da_o = 0;
    for (int c = 1; c <= 44; c++) begin
      obs[c-1] = tx_serial_0;
      ob_e[c-1] = tx_serial_e;
      ob_o[c-1] = tx_serial_o;
      if (tx_active_0) act_cnt++;
      if (tx_active_e) act_e++;
      if (tx_active_o) act_o++;
      if (tx_done_0 && da_0 == 0) da_0 = c;
      if (tx_done_e && da_e == 0) da_e = c;
      if (tx_done_o && da_o == 0) da_o = c;
      tick();
    end
    fl = frame_line(8'h41, 1'b0, 1'b0);
    check("f41_line", 64'(obs[43:0]), 64'(fl[43:0]));
    check("f41_active_cycles", 64'(act_cnt), 64'd40);
    check("f41_done_cycle", 64'(da_0), 64'd40);
    check("f41_done_count", 64'(done_cnt - d0), 64'd1);
    check("f41_idle_after", 64'({tx_active_0, tx_serial_0}), 64'b01);
    fl = frame_line(8'h41, 1'b1, 1'b0);
    check("f41_even_line", 64'(ob_e), 64'(fl[43:0]));
    check("f41_even_parity_bit", 64'(ob_e[39:36]), 64'h0);
    check("f41_even_done_cycle", 64'(da_e), 64'd44);
    check("f41_even_active_cycles", 64'(act_e), 64'd44);
    fl = frame_line(8'h41, 1'b1, 1'b1);
    check("f41_odd_line", 64'(ob_o), 64'(fl[43:0]));
    check("f41_odd_parity_bit", 64'(ob_o[39:36]), 64'hF);
    check("f41_odd_done_cycle", 64'(da_o), 64'd44);
    check("f41_odd_active_cycles", 64'(act_o), 64'd44);
    check("f41_parity_overrun", 64'({overrun_e, overrun_o}), 64'd0);
    tick();

    // ---------------- 0x55 then 0xAA queued during DATA ----------------
    run_seq(8'h55, 10, 8'hAA, 0, 8'h00, 84);
    fl = frame_line(8'h55, 1'b0, 1'b0);
    fl2 = frame_line(8'hAA, 1'b0, 1'b0);
    check("b2b_frame1", 64'(obs[39:0]), 64'(fl[39:0]));
    check("b2b_frame2", 64'(obs[79:40]), 64'(fl2[39:0]));
    check("b2b_idle_tail", 64'(obs[83:80]), 64'hF);
    check("b2b_active_cycles", 64'(act_cnt), 64'd80);
    check("b2b_done_cycles", 64'({done_first[7:0], done_last[7:0]}), 64'({8'd40, 8'd80}));
    check("b2b_overrun", 64'(overrun_0), 64'd0);
    tick();

    // ---------------- send on the tx_done cycle: direct start ----------------
    run_seq(8'h55, 40, 8'h12, 0, 8'h00, 84);
    fl2 = frame_line(8'h12, 1'b0, 1'b0);
    check("done_send_frame2", 64'(obs[79:40]), 64'(fl2[39:0]));
    check("done_send_ndone", 64'(n_done), 64'd2);
    check("done_send_last", 64'(done_last), 64'd80);
    check("done_send_overrun", 64'(overrun_0), 64'd0);
    tick();

    // ---------------- third send with buffer full: dropped ----------------
    run_seq(8'h55, 10, 8'hAA, 15, 8'h33, 92);
    fl = frame_line(8'h55, 1'b0, 1'b0);
    fl2 = frame_line(8'hAA, 1'b0, 1'b0);
    check("ovr_frame1", 64'(obs[39:0]), 64'(fl[39:0]));
    check("ovr_frame2", 64'(obs[79:40]), 64'(fl2[39:0]));
    check("ovr_no_third_frame", 64'(obs[91:80]), 64'hFFF);
    check("ovr_ndone", 64'(n_done), 64'd2);
    check("ovr_flag", 64'(overrun_0), 64'd1);
    repeat (5) tick();
    check("ovr_sticky", 64'(overrun_0), 64'd1);

    // ---------------- reset in the middle of DATA of 0xFF ----------------
    send_byte(8'hFF);
    repeat (14) tick();
    d0 = done_cnt;
    check("mid_pre_active", 64'(tx_active_0), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_serial", 64'(tx_serial_0), 64'd1);
    check("mid_rst_active", 64'(tx_active_0), 64'd0);
    check("mid_rst_overrun", 64'(overrun_0), 64'd0);
    repeat (3) tick();
    check("mid_rst_hold", 64'({tx_serial_0, tx_active_0, tx_done_0}), 64'b100);
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    reset = 1'b1;
    tick();
    run_seq(8'h0F, 0, 8'h00, 0, 8'h00, 44);
    fl = frame_line(8'h0F, 1'b0, 1'b0);
    check("post_rst_line", 64'(obs[43:0]), 64'(fl[43:0]));
    check("post_rst_done", 64'({n_done[7:0], done_first[7:0]}), 64'({8'd1, 8'd40}));
    check("post_rst_active", 64'(act_cnt), 64'd40);
    tick();

    // ---------------- upstream-like loop: "e2e4" + 3 pad ----------------
    msg[0] = 8'h65; msg[1] = 8'h32; msg[2] = 8'h65; msg[3] = 8'h34;
    msg[4] = 8'h20; msg[5] = 8'h20; msg[6] = 8'h20;
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) begin
      send_byte(msg[i]);
      obs = '1;
      dat = 0;
      for (int c = 1; c <= 60 && dat == 0; c++) begin
        obs[c-1] = tx_serial_0;
        if (tx_done_0) dat = c;
        tick();
      end
      fl = frame_line(msg[i], 1'b0, 1'b0);
      check($sformatf("loop%0d_line", i), 64'(obs[39:0]), 64'(fl[39:0]));
      check($sformatf("loop%0d_done_cycle", i), 64'(dat), 64'd40);
      tick();
    end
    check("loop_done_count", 64'(done_cnt - d0), 64'd7);
    check("loop_overrun", 64'(overrun_0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-level UART transmitter directly downstream of the move-string transmitter.
- Consumes one `tx_byte` per `send` pulse and shifts it out on a single serial line as 8N1, with optional parity.
- Returns a one-cycle `tx_done` pulse per completed frame; the upstream byte sequencer uses it to advance to the next non-zero byte.
- Includes a one-deep pending buffer, so a `send` arriving during an active frame is not lost.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit between the data bits and the stop bit.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tx_byte  input  8  byte to transmit; sampled only on a cycle where `send` = 1.
- send  input  1  one-cycle request to transmit `tx_byte`.
- tx_serial  output  1  serial line; idle high.
- tx_active  output  1  high from the first cycle of the start bit through the last cycle of the stop bit.
- tx_done  output  1  one-cycle pulse on the final cycle of each stop bit.
- overrun  output  1  sticky: set when a `send` is dropped; cleared only by reset.

Behaviour:
- Reset (async, `reset` = 0):
  - Outputs: `tx_serial` = 1, `tx_active` = 0, `tx_done` = 0, `overrun` = 0.
  - Internal: state = IDLE, pending buffer empty, baud counter = 0, bit index = 0.
  - Effect is immediate even mid-frame; the line returns high without completing the frame and no `tx_done` is issued.
- Baud counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 within each bit, then wraps to 0 and advances the bit.
- Bit index: 3 bits, 0..7. Data is sent LSB first.
- FSM states:
  - IDLE: `tx_serial` = 1, `tx_active` = 0.
    - If the pending buffer is full: load its byte into the shift register, empty the buffer, go to START.
    - Else if `send` = 1: load `tx_byte`, go to START.
  - START: `tx_serial` = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx_serial` = shift[bit index] for CLKS_PER_BIT cycles per bit.
    - After bit 7: go to PARITY if PARITY_EN = 1, else STOP.
  - PARITY: `tx_serial` = XOR of the 8 data bits, XOR PARITY_ODD, held for CLKS_PER_BIT cycles; then STOP.
  - STOP: `tx_serial` = 1 for CLKS_PER_BIT cycles.
    - On the last cycle, `tx_done` = 1 for exactly one cycle.
    - Next state is START if the pending buffer is full or `send` = 1 that cycle, otherwise IDLE.
- Latency:
  - `send` sampled high in IDLE: `tx_serial` falls on the following cycle.
  - Frame length = (10 + PARITY_EN) × CLKS_PER_BIT cycles, measured from the first start-bit cycle to `tx_done` inclusive.
- Back-to-back frames: no idle gap; the next start bit begins the cycle after `tx_done`.
- `send` while busy (state ≠ IDLE):
  - Pending buffer empty: byte captured, buffer becomes full.
  - Pending buffer full: byte dropped, `overrun` set.
  - `send` on the last STOP cycle (the `tx_done` cycle) is treated as a direct start, not pending; if the buffer is already full, that `send` is dropped and `overrun` is set.
- `tx_byte` is not required to be stable after the `send` cycle.
- Upstream contract: one `send` per `tx_done`. `overrun` = 1 therefore indicates an upstream protocol error.

Test Plan:
- CLKS_PER_BIT = 4, PARITY_EN = 0; `send` with `tx_byte` = 0x41 in IDLE:
  - Line sequence, 4 cycles each: 0 | 1,0,0,0,0,0,1,0 | 1.
  - `tx_active` high for 40 cycles.
  - `tx_done` pulses on cycle 40, then return to IDLE.
- PARITY_EN = 1, PARITY_ODD = 0, byte 0x41: parity bit = 0, `tx_done` on cycle 44. With PARITY_ODD = 1: parity bit = 1.
- `send` 0x55 at IDLE, then `send` 0xAA during the DATA state:
  - Two contiguous frames; the second start bit immediately follows the first frame's `tx_done`.
  - `overrun` stays 0.
- Third `send` while the pending buffer is full: byte discarded, `overrun` = 1 and stays 1, the two accepted frames are unaffected.
- `reset` driven low mid-DATA of byte 0xFF:
  - `tx_serial` = 1 and `tx_active` = 0 immediately, no `tx_done` pulse.
  - After release, `send` 0x0F produces a clean, complete frame.
- Upstream-like loop: seven bytes "e2e4" + pad, each `send` issued two cycles after the prior `tx_done`. Expect exactly seven `tx_done` pulses, the bytes on the line in order, and `overrun` = 0.
